// File: rtl/bus_pkg.sv
// Shared definitions for the bridge-side bus arbiter: datapath widths and FSM state encoding.
package bus_pkg;
  localparam int DATA_W   = 32;
  localparam int BYTEEN_W = 4;
  localparam int GID_W    = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;
endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first requesting master after i_last_grant, wrapping to 0.
module rr_picker
  import bus_pkg::*;
#(
  parameter int NUM_M = 2
) (
  input  logic [NUM_M-1:0] i_req,
  input  logic [GID_W-1:0] i_last_grant,
  output logic [GID_W-1:0] o_gnt_idx,
  output logic             o_any
);
  logic [NUM_M-1:0] w_hi_mask;
  logic [NUM_M-1:0] w_hi_req;
  logic [GID_W-1:0] w_lo_idx;
  logic [GID_W-1:0] w_hi_idx;

  always_comb begin
    w_hi_mask = '0;
    for (int i = 0; i < NUM_M; i++) begin
      w_hi_mask[i] = (i > int'(i_last_grant));
    end
  end

  assign w_hi_req = i_req & w_hi_mask;

  // Downward scan leaves the lowest set index in each candidate.
  always_comb begin
    w_lo_idx = '0;
    w_hi_idx = '0;
    for (int i = NUM_M - 1; i >= 0; i--) begin
      if (i_req[i])    w_lo_idx = GID_W'(i);
      if (w_hi_req[i]) w_hi_idx = GID_W'(i);
    end
  end

  assign o_any     = |i_req;
  assign o_gnt_idx = (|w_hi_req) ? w_hi_idx : w_lo_idx;
endmodule

// File: rtl/bus_arbiter.sv
// Round-robin arbiter sharing the bridge data port between NUM_M req/ack masters, one transaction at a time.
// Handshake: a master holds m_req until it sees its one-cycle m_ack; m_req is only sampled in IDLE.
module bus_arbiter
  import bus_pkg::*;
#(
  parameter int NUM_M  = 2,
  parameter int RD_LAT = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_M-1:0]          m_req,
  input  logic [NUM_M*DATA_W-1:0]   m_addr,
  input  logic [NUM_M*DATA_W-1:0]   m_wd,
  input  logic [NUM_M*BYTEEN_W-1:0] m_byteen,
  output logic [NUM_M-1:0]          m_ack,
  output logic [31:0]               m_rd,
  output logic [31:0]               t_addr,
  output logic [31:0]               t_WD,
  output logic [3:0]                t_byteen,
  input  logic [31:0]               t_RD,
  output logic                      busy,
  output logic [2:0]                grant_id,
  output logic [1:0]                o_dbg_state
);
  localparam logic [2:0] CNT_INIT = 3'(RD_LAT - 1);

  state_e                r_state, w_nxt_state;
  logic [2:0]            r_cnt, w_nxt_cnt;
  logic [GID_W-1:0]      r_last_grant, w_nxt_last_grant;
  logic [GID_W-1:0]      r_gid, w_nxt_gid;
  logic [DATA_W-1:0]     r_addr, w_nxt_addr;
  logic [DATA_W-1:0]     r_wd, w_nxt_wd;
  logic [BYTEEN_W-1:0]   r_be, w_nxt_be;
  logic [NUM_M-1:0]      r_ack, w_nxt_ack;
  logic [DATA_W-1:0]     r_rd, w_nxt_rd;
  logic [DATA_W-1:0]     r_t_addr, w_nxt_t_addr;
  logic [DATA_W-1:0]     r_t_wd, w_nxt_t_wd;
  logic [BYTEEN_W-1:0]   r_t_be, w_nxt_t_be;
  logic                  r_busy;

  logic [GID_W-1:0]      w_gnt_idx;
  logic                  w_any;
  logic [DATA_W-1:0]     w_sel_addr;
  logic [DATA_W-1:0]     w_sel_wd;
  logic [BYTEEN_W-1:0]   w_sel_be;

  rr_picker #(.NUM_M(NUM_M)) u_picker (
    .i_req        (m_req),
    .i_last_grant (r_last_grant),
    .o_gnt_idx    (w_gnt_idx),
    .o_any        (w_any)
  );

  assign w_sel_addr = DATA_W'(m_addr >> (DATA_W * int'(w_gnt_idx)));
  assign w_sel_wd   = DATA_W'(m_wd >> (DATA_W * int'(w_gnt_idx)));
  assign w_sel_be   = BYTEEN_W'(m_byteen >> (BYTEEN_W * int'(w_gnt_idx)));

  // Output registers are loaded with the values for the state being entered.
  always_comb begin
    w_nxt_state      = r_state;
    w_nxt_cnt        = r_cnt;
    w_nxt_last_grant = r_last_grant;
    w_nxt_gid        = r_gid;
    w_nxt_addr       = r_addr;
    w_nxt_wd         = r_wd;
    w_nxt_be         = r_be;
    w_nxt_ack        = '0;
    w_nxt_rd         = '0;
    w_nxt_t_addr     = '0;
    w_nxt_t_wd       = '0;
    w_nxt_t_be       = '0;
    case (r_state)
      ST_IDLE: begin
        if (w_any) begin
          w_nxt_state  = ST_ISSUE;
          w_nxt_gid    = w_gnt_idx;
          w_nxt_addr   = w_sel_addr;
          w_nxt_wd     = w_sel_wd;
          w_nxt_be     = w_sel_be;
          w_nxt_t_addr = w_sel_addr;
          w_nxt_t_wd   = w_sel_wd;
          w_nxt_t_be   = w_sel_be;
        end
      end
      ST_ISSUE: begin
        if (r_be != '0) begin
          w_nxt_state = ST_DONE;
          w_nxt_ack   = NUM_M'(1) << r_gid;
        end else begin
          w_nxt_state  = ST_WAIT;
          w_nxt_cnt    = CNT_INIT;
          w_nxt_t_addr = r_addr;
        end
      end
      ST_WAIT: begin
        if (r_cnt == 3'd0) begin
          w_nxt_state = ST_DONE;
          w_nxt_rd    = t_RD;
          w_nxt_ack   = NUM_M'(1) << r_gid;
        end else begin
          w_nxt_cnt    = r_cnt - 3'd1;
          w_nxt_t_addr = r_addr;
        end
      end
      ST_DONE: begin
        w_nxt_state      = ST_IDLE;
        w_nxt_last_grant = r_gid;
        w_nxt_gid        = '0;
      end
      default: w_nxt_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_last_grant <= GID_W'(NUM_M - 1);
      r_gid        <= '0;
      r_addr       <= '0;
      r_wd         <= '0;
      r_be         <= '0;
      r_ack        <= '0;
      r_rd         <= '0;
      r_t_addr     <= '0;
      r_t_wd       <= '0;
      r_t_be       <= '0;
      r_busy       <= 1'b0;
    end else begin
      r_state      <= w_nxt_state;
      r_cnt        <= w_nxt_cnt;
      r_last_grant <= w_nxt_last_grant;
      r_gid        <= w_nxt_gid;
      r_addr       <= w_nxt_addr;
      r_wd         <= w_nxt_wd;
      r_be         <= w_nxt_be;
      r_ack        <= w_nxt_ack;
      r_rd         <= w_nxt_rd;
      r_t_addr     <= w_nxt_t_addr;
      r_t_wd       <= w_nxt_t_wd;
      r_t_be       <= w_nxt_t_be;
      r_busy       <= (w_nxt_state != ST_IDLE);
    end
  end

  assign m_ack       = r_ack;
  assign m_rd        = r_rd;
  assign t_addr      = r_t_addr;
  assign t_WD        = r_t_wd;
  assign t_byteen    = r_t_be;
  assign busy        = r_busy;
  assign grant_id    = r_gid;
  assign o_dbg_state = r_state;
endmodule
